// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and the address range check for regfile_nrd_1wr.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REGFILE_DATA_W = 8;
    localparam int REGFILE_DEPTH  = 4;
    localparam int REGFILE_NUM_RD = 2;

    // DEPTH need not be a power of two, so the top of the address space can be invalid
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One registered read port: address mux, range check, optional
//               write-first bypass (REGFILE_BYPASS_EN) and valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int                DATA_W  = REGFILE_DATA_W,
    parameter int                DEPTH   = REGFILE_DEPTH,
    parameter int                ADDR_W  = $clog2(REGFILE_DEPTH),
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef REGFILE_BYPASS_EN
    input  logic                    i_wr_en,
    input  logic                    i_wr_ok,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
`endif
    input  logic [DEPTH*DATA_W-1:0] i_mem,
    input  logic                    i_r_en,
    input  logic [ADDR_W-1:0]       i_r_addr,
    output logic [DATA_W-1:0]       o_r_data,
    output logic                    o_r_valid,
    output logic                    o_addr_err
);

    logic              w_in_range;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    assign w_in_range = addr_in_range(32'(i_r_addr), DEPTH);

    // Addresses past DEPTH match no entry and fall through to RST_VAL
    always_comb begin
        w_rd_word = RST_VAL;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_r_addr == ADDR_W'(i)) begin
                w_rd_word = i_mem[i*DATA_W +: DATA_W];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (i_wr_en && i_wr_ok && (i_wr_addr == i_r_addr)) begin
            w_rd_word = i_wr_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_r_en;
            if (i_r_en) begin
                r_data <= w_rd_word;
            end
        end
    end

    assign o_r_data   = r_data;
    assign o_r_valid  = r_valid;
    assign o_addr_err = i_r_en & ~w_in_range;

endmodule
`default_nettype wire

// File: rtl/regfile_nrd_1wr.sv
`default_nettype none
// ============================================================================
// Module      : regfile_nrd_1wr
// Description : DEPTH x DATA_W register file, one write port, NUM_RD registered
//               read ports, sticky out-of-range flag. Macro: REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_nrd_1wr
    import regfile_pkg::*;
#(
    parameter  int                DATA_W  = REGFILE_DATA_W,
    parameter  int                DEPTH   = REGFILE_DEPTH,
    parameter  int                NUM_RD  = REGFILE_NUM_RD,
    parameter  logic [DATA_W-1:0] RST_VAL = '0,
    localparam int                ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [NUM_RD-1:0]        r_en,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    output logic [NUM_RD*DATA_W-1:0] r_data,
    output logic [NUM_RD-1:0]        r_valid,
    output logic                     addr_err
);

    logic [DEPTH*DATA_W-1:0] r_mem;
    logic                    r_addr_err;
    logic                    w_wr_ok;
    logic [NUM_RD-1:0]       w_rd_err;

    assign w_wr_ok = addr_in_range(32'(w_addr), DEPTH);

    // Out-of-range write addresses match no entry, so the write is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem <= {DEPTH{RST_VAL}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_en && (w_addr == ADDR_W'(i))) begin
                    r_mem[i*DATA_W +: DATA_W] <= w_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else if ((w_en && !w_wr_ok) || (|w_rd_err)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
            regfile_rd_port #(
                .DATA_W  (DATA_W),
                .DEPTH   (DEPTH),
                .ADDR_W  (ADDR_W),
                .RST_VAL (RST_VAL)
            ) u_rd_port (
                .clk        (clk),
                .rst        (rst),
`ifdef REGFILE_BYPASS_EN
                .i_wr_en    (w_en),
                .i_wr_ok    (w_wr_ok),
                .i_wr_addr  (w_addr),
                .i_wr_data  (w_data),
`endif
                .i_mem      (r_mem),
                .i_r_en     (r_en[k]),
                .i_r_addr   (r_addr[k*ADDR_W +: ADDR_W]),
                .o_r_data   (r_data[k*DATA_W +: DATA_W]),
                .o_r_valid  (r_valid[k]),
                .o_addr_err (w_rd_err[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_nrd_1wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_nrd_1wr
// Description : Self-checking bench: default 4-entry file against a behavioural
//               model, plus a 5-entry instance for out-of-range behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_nrd_1wr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        w_en;
    logic [1:0]  w_addr;
    logic [7:0]  w_data;
    logic [1:0]  r_en;
    logic [3:0]  r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_valid;
    logic        addr_err;

    logic        b_w_en;
    logic [2:0]  b_w_addr;
    logic [7:0]  b_w_data;
    logic [1:0]  b_r_en;
    logic [5:0]  b_r_addr;
    logic [15:0] b_r_data;
    logic [1:0]  b_r_valid;
    logic        b_addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [4];
    logic [7:0] m_data [2];
    logic [1:0] m_valid;

    regfile_nrd_1wr dut (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid), .addr_err(addr_err)
    );

    regfile_nrd_1wr #(.DATA_W(8), .DEPTH(5), .NUM_RD(2), .RST_VAL(8'h5A)) dut5 (
        .clk(clk), .rst(rst), .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
        .r_en(b_r_en), .r_addr(b_r_addr), .r_data(b_r_data), .r_valid(b_r_valid), .addr_err(b_addr_err)
    );

    task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic [1:0] re, input logic [1:0] ra0, input logic [1:0] ra1);
        w_en = we; w_addr = wa; w_data = wd; r_en = re; r_addr = {ra1, ra0};
    endtask

    task automatic drive_b(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic [1:0] re, input logic [2:0] ra0, input logic [2:0] ra1);
        b_w_en = we; b_w_addr = wa; b_w_data = wd; b_r_en = re; b_r_addr = {ra1, ra0};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        m_data[0] = 8'h00; m_data[1] = 8'h00; m_valid = 2'b00;
    endtask

    // Advance one edge: read ports see pre-write contents unless bypass is built in
    task automatic tick();
        logic [1:0] a;
        for (int k = 0; k < 2; k++) begin
            if (r_en[k]) begin
                a = r_addr[k*2 +: 2];
                m_data[k] = m_mem[a];
`ifdef REGFILE_BYPASS_EN
                if (w_en && (w_addr == a)) m_data[k] = w_data;
`endif
                m_valid[k] = 1'b1;
            end else begin
                m_valid[k] = 1'b0;
            end
        end
        if (w_en) m_mem[w_addr] = w_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #12;
        n_tests++; if (r_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", r_data); end
        n_tests++; if (r_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", r_valid); end
        n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", addr_err); end
        n_tests++; if (b_r_data !== 16'h5A5A) begin n_fail++; $display("FAIL reset_rstval: got %h want 5a5a", b_r_data); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 2'b11, 2'(i), 2'(3 - i));
            tick();
            n_tests++; if (r_data !== 16'h0000 || r_valid !== 2'b11) begin
                n_fail++; $display("FAIL reset_read%0d: got %h/%b want 0000/11", i, r_data, r_valid);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_tests++; if (r_valid !== 2'b00 || addr_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got valid %b err %b want 00 0", r_valid, addr_err);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] vals [4];
        vals = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), vals[i], 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 2'b11, 2'd2, 2'd3);
        tick();
        n_tests++; if (r_data !== 16'h0FF0 || r_valid !== 2'b11) begin
            n_fail++; $display("FAIL write_read: got %h/%b want 0ff0/11", r_data, r_valid);
        end
    endtask

    task automatic test_collision();
        logic [7:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 8'h55;
`else
        want = 8'h3C;
`endif
        drive(1, 2'd1, 8'h55, 2'b01, 2'd1, 2'd0);
        tick();
        n_tests++; if (r_data[7:0] !== want || r_valid !== 2'b01) begin
            n_fail++; $display("FAIL collision: got %h/%b want %h/01", r_data[7:0], r_valid, want);
        end
        drive(0, 0, 0, 2'b01, 2'd1, 2'd0);
        tick();
        n_tests++; if (r_data[7:0] !== 8'h55) begin
            n_fail++; $display("FAIL collision_next: got %h want 55", r_data[7:0]);
        end
    endtask

    task automatic test_hold();
        drive(0, 0, 0, 2'b01, 2'd0, 2'd0);
        tick();
        n_tests++; if (r_data[7:0] !== 8'hA5 || r_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL hold_read: got %h/%b want a5/1", r_data[7:0], r_valid[0]);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (r_data[7:0] !== 8'hA5 || r_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL hold_idle%0d: got %h/%b want a5/0", i, r_data[7:0], r_valid[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 2'($urandom), 8'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom));
            tick();
            n_tests++; if (r_data !== {m_data[1], m_data[0]} || r_valid !== m_valid || addr_err !== 1'b0) begin
                n_fail++; $display("FAIL random%0d: got %h/%b/%b want %h/%b/0", n, r_data, r_valid,
                                   addr_err, {m_data[1], m_data[0]}, m_valid);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_range();
        drive_b(1, 3'd6, 8'h77, 2'b00, 0, 0);
        tick();
        n_tests++; if (b_addr_err !== 1'b1) begin n_fail++; $display("FAIL range_wr_err: got %b want 1", b_addr_err); end
        drive_b(0, 0, 0, 2'b11, 3'd6, 3'd4);
        tick();
        n_tests++; if (b_r_data !== 16'h5A5A || b_r_valid !== 2'b11) begin
            n_fail++; $display("FAIL range_read: got %h/%b want 5a5a/11", b_r_data, b_r_valid);
        end
        drive_b(1, 3'd4, 8'h11, 2'b01, 3'd1, 3'd0);
        tick();
        n_tests++; if (b_r_data[7:0] !== 8'h5A) begin n_fail++; $display("FAIL range_alias: got %h want 5a", b_r_data[7:0]); end
        drive_b(0, 0, 0, 2'b10, 3'd0, 3'd4);
        tick();
        n_tests++; if (b_r_data[15:8] !== 8'h11 || b_addr_err !== 1'b1) begin
            n_fail++; $display("FAIL range_top: got %h err %b want 11 err 1", b_r_data[15:8], b_addr_err);
        end
        drive_b(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        drive(1, 2'd2, 8'h99, 0, 0, 0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (r_data !== 16'h0000 || r_valid !== 2'b00 || addr_err !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_a: got %h/%b/%b want 0000/00/0", r_data, r_valid, addr_err);
        end
        n_tests++; if (b_addr_err !== 1'b0 || b_r_data !== 16'h5A5A) begin
            n_fail++; $display("FAIL async_rst_b: got err %b data %h want 0 5a5a", b_addr_err, b_r_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 2'd3, 8'hC3, 2'b01, 2'd2, 2'd0);
        tick();
        n_tests++; if (r_data[7:0] !== 8'h00 || r_valid !== 2'b01) begin
            n_fail++; $display("FAIL async_rst_read: got %h/%b want 00/01", r_data[7:0], r_valid);
        end
        drive(0, 0, 0, 2'b10, 2'd0, 2'd3);
        tick();
        n_tests++; if (r_data[15:8] !== 8'hC3) begin
            n_fail++; $display("FAIL async_first_wr: got %h want c3", r_data[15:8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        test_reset();
        test_write_read();
        test_collision();
        test_hold();
        test_random();
        test_range();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
